// File: rtl/peripheral_uart_tx_fifo_if.sv
// Write handshake between the APB4 register front-end (master) and the UART transmit FIFO (slave).
interface peripheral_uart_tx_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;

    modport master (output wr_valid, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface

// File: rtl/peripheral_uart_tx_fifo.sv
// Parametrised UART transmit engine with built-in FIFO (5-8 data bits, optional parity, 1/2 stop bits).
// Optional line-break support is compiled in when UART_TX_BREAK_EN is defined.
module peripheral_uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [DIV_WIDTH-1:0]            cfg_div_i,
    input  logic [1:0]                      cfg_bits_i,
    input  logic                            cfg_parity_en_i,
    input  logic                            cfg_parity_odd_i,
    input  logic                            cfg_stop2_i,
`ifdef UART_TX_BREAK_EN
    input  logic                            break_i,
`endif
    peripheral_uart_tx_fifo_if.slave        wr,
    output logic                            tx_o,
    output logic                            busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o,
    output logic                            event_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]        FULL = CW'(FIFO_DEPTH);
    localparam logic [DIV_WIDTH-1:0] ONE  = DIV_WIDTH'(1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    function automatic logic frame_parity(input logic [DATA_WIDTH-1:0] d, input logic [1:0] bits,
                                          input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < 8; i++) begin
            if (i < 5 + int'(bits)) p = p ^ d[i];
        end
        return p;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  push, pop, fifo_nonempty;
    logic [DATA_WIDTH-1:0] head;

    state_t                state_q;
    logic                  tx_q, busy_q, event_q;
    logic [DIV_WIDTH-1:0]  cnt_q, div_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [2:0]            bitidx_q;
    logic [1:0]            bits_q;
    logic                  par_en_q, par_bit_q, stop2_q, stop_sec_q;
    logic                  bit_end, stop_end, last_bit, idle_go, chain_go;

    assign wr.wr_ready    = (count_q != FULL);
    assign push           = wr.wr_valid && wr.wr_ready;
    assign fifo_nonempty  = (count_q != '0);
    assign head           = mem_q[rd_ptr_q];
    assign fifo_count_o   = count_q;

    assign bit_end  = (cnt_q == '0);
    assign last_bit = (bitidx_q == (3'd4 + {1'b0, bits_q}));
    assign stop_end = (state_q == S_STOP) && bit_end && (!stop2_q || stop_sec_q);

`ifdef UART_TX_BREAK_EN
    logic brk_q;
    // A pending break, or the guard bit period after it, keeps the FSM parked in IDLE.
    assign idle_go  = !break_i && !brk_q;
    assign chain_go = !break_i;
`else
    assign idle_go  = 1'b1;
    assign chain_go = 1'b1;
`endif

    assign pop = fifo_nonempty && (((state_q == S_IDLE) && idle_go) || (stop_end && chain_go));

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= wr.wr_data;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            event_q    <= 1'b0;
            cnt_q      <= '0;
            stop_sec_q <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_q      <= 1'b0;
`endif
        end else begin
            event_q <= 1'b0;
            if (pop) begin
                // Frame configuration is frozen here for the whole frame.
                state_q    <= S_START;
                busy_q     <= 1'b1;
                tx_q       <= 1'b0;
                cnt_q      <= cfg_div_i;
                div_q      <= cfg_div_i;
                bits_q     <= cfg_bits_i;
                par_en_q   <= cfg_parity_en_i;
                par_bit_q  <= frame_parity(head, cfg_bits_i, cfg_parity_odd_i);
                stop2_q    <= cfg_stop2_i;
                shift_q    <= head;
                bitidx_q   <= '0;
                stop_sec_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
`ifdef UART_TX_BREAK_EN
                        if (break_i) begin
                            tx_q  <= 1'b0;
                            brk_q <= 1'b1;
                            cnt_q <= cfg_div_i;
                        end else if (brk_q) begin
                            tx_q <= 1'b1;
                            if (bit_end) brk_q <= 1'b0;
                            else         cnt_q <= cnt_q - ONE;
                        end
`endif
                    end
                    S_START: begin
                        if (bit_end) begin
                            state_q  <= S_DATA;
                            tx_q     <= shift_q[0];
                            shift_q  <= shift_q >> 1;
                            bitidx_q <= '0;
                            cnt_q    <= div_q;
                        end else cnt_q <= cnt_q - ONE;
                    end
                    S_DATA: begin
                        if (bit_end) begin
                            cnt_q <= div_q;
                            if (last_bit) begin
                                state_q <= par_en_q ? S_PARITY : S_STOP;
                                tx_q    <= par_en_q ? par_bit_q : 1'b1;
                            end else begin
                                bitidx_q <= bitidx_q + 3'd1;
                                tx_q     <= shift_q[0];
                                shift_q  <= shift_q >> 1;
                            end
                        end else cnt_q <= cnt_q - ONE;
                    end
                    S_PARITY: begin
                        if (bit_end) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                            cnt_q   <= div_q;
                        end else cnt_q <= cnt_q - ONE;
                    end
                    S_STOP: begin
                        if (bit_end) begin
                            if (stop2_q && !stop_sec_q) begin
                                stop_sec_q <= 1'b1;
                                cnt_q      <= div_q;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                event_q <= !fifo_nonempty;
                            end
                        end else cnt_q <= cnt_q - ONE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign tx_o    = tx_q;
    assign busy_o  = busy_q;
    assign event_o = event_q;
endmodule

// File: tb/tb_peripheral_uart_tx_fifo.sv
// Scoreboard bench for peripheral_uart_tx_fifo: a line-level model predicts every cycle's outputs.
module tb_peripheral_uart_tx_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        RST;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_bits;
    logic        cfg_pen, cfg_podd, cfg_stop2;
    logic        brk;
    logic        tx, busy, evt;
    logic [4:0]  cnt;

    peripheral_uart_tx_fifo_if #(.DATA_WIDTH(8)) wr_if ();

    peripheral_uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(16), .DATA_WIDTH(8)) dut (
        .CLK              (clk),
        .RST              (RST),
        .cfg_div_i        (cfg_div),
        .cfg_bits_i       (cfg_bits),
        .cfg_parity_en_i  (cfg_pen),
        .cfg_parity_odd_i (cfg_podd),
        .cfg_stop2_i      (cfg_stop2),
`ifdef UART_TX_BREAK_EN
        .break_i          (brk),
`endif
        .wr               (wr_if),
        .tx_o             (tx),
        .busy_o           (busy),
        .fifo_count_o     (cnt),
        .event_o          (evt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       tx;
        logic       busy;
        logic       evt;
        logic [4:0] cnt;
        logic       rdy;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mfifo[$];
    bit         wave[$];      // expected line level for each upcoming cycle of the current frame
    bit         brk_active;
    int         hold;
    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc   = 0;

    // Expand one byte into per-cycle line levels using the configuration present at pop time.
    function automatic void build_wave(input logic [7:0] d);
        bit lv[$];
        bit p;
        int nb, reps;
        nb   = 5 + int'(cfg_bits);
        reps = int'(cfg_div) + 1;
        p    = cfg_podd;
        lv.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            lv.push_back(d[i]);
            p = p ^ d[i];
        end
        if (cfg_pen) lv.push_back(p);
        lv.push_back(1'b1);
        if (cfg_stop2) lv.push_back(1'b1);
        foreach (lv[k]) repeat (reps) wave.push_back(lv[k]);
    endfunction

    // Reference model: advances one cycle per rising edge and queues the outputs it expects next.
    bit   m_accept, m_was_idle, m_ended, m_pop, m_evt, m_brk_in;
    exp_t m_e;
    always @(posedge clk) begin
        cyc++;
`ifdef UART_TX_BREAK_EN
        m_brk_in = brk;
`else
        m_brk_in = 1'b0;
`endif
        m_accept = wr_if.wr_valid && (mfifo.size() < DEPTH);
        if (RST) begin
            mfifo.delete();
            wave.delete();
            brk_active = 1'b0;
            hold = 0;
            m_evt = 1'b0;
        end else begin
            m_was_idle = (wave.size() == 0);
            m_ended = 1'b0;
            m_pop = 1'b0;
            m_evt = 1'b0;
            if (!m_was_idle) begin
                void'(wave.pop_front());
                m_ended = (wave.size() == 0);
            end
            if (m_ended) begin
                if (mfifo.size() > 0 && !m_brk_in) m_pop = 1'b1;
                else m_evt = (mfifo.size() == 0);
            end else if (m_was_idle) begin
                if (m_brk_in) brk_active = 1'b1;
                else if (brk_active) begin
                    brk_active = 1'b0;
                    hold = int'(cfg_div);
                end else if (hold > 0) hold--;
                else if (mfifo.size() > 0) m_pop = 1'b1;
            end
            if (m_pop) build_wave(mfifo.pop_front());
            if (m_accept) mfifo.push_back(wr_if.wr_data);
        end
        m_e.tx   = (wave.size() > 0) ? wave[0] : !brk_active;
        m_e.busy = (wave.size() > 0);
        m_e.evt  = m_evt;
        m_e.cnt  = 5'(mfifo.size());
        m_e.rdy  = (mfifo.size() < DEPTH);
        exp_q.push_back(m_e);
    end

    // Monitor: compares what the DUT presents against the oldest queued expectation.
    exp_t ex;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            n_vec++;
            if ({tx, busy, evt, cnt, wr_if.wr_ready} !== ex) begin
                n_bad++;
                $display("FAIL outputs cyc=%0d got tx=%b busy=%b event=%b count=%0d ready=%b expected tx=%b busy=%b event=%b count=%0d ready=%b",
                         cyc, tx, busy, evt, cnt, wr_if.wr_ready, ex.tx, ex.busy, ex.evt, ex.cnt, ex.rdy);
            end
        end
    end

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = d;
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic burst(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = 8'($urandom);
        end
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic set_cfg(input int div, input int bits, input bit pen, input bit podd, input bit st2);
        cfg_div   = 16'(div);
        cfg_bits  = 2'(bits);
        cfg_pen   = pen;
        cfg_podd  = podd;
        cfg_stop2 = st2;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((mfifo.size() != 0 || wave.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (mfifo.size() != 0 || wave.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout budget=%0d pending=%0d required=0", budget, mfifo.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        RST = 1'b1;
        brk = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;
        set_cfg(3, 3, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        RST = 1'b0;

        // 8N1, 4 cycles per bit, single frame
        send(8'hA5);
        wait_idle(100);

        // 5 data bits, odd parity, 1 cycle per bit
        set_cfg(0, 0, 1'b1, 1'b1, 1'b0);
        send(8'h13);
        wait_idle(40);

        // fill while busy: 16 queued, 17th dropped, frames back-to-back
        set_cfg(3, 3, 1'b0, 1'b0, 1'b0);
        send(8'h3C);
        repeat (2) @(negedge clk);
        burst(17);
        wait_idle(1200);

        // stop-bit count changed mid-frame applies to the next frame only
        set_cfg(1, 3, 1'b1, 1'b0, 1'b0);
        burst(2);
        repeat (3) @(negedge clk);
        cfg_stop2 = 1'b1;
        wait_idle(200);
        cfg_stop2 = 1'b0;

        // reset in the middle of a data bit with entries pending
        set_cfg(2, 3, 1'b0, 1'b0, 1'b0);
        burst(6);
        repeat (4) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        repeat (10) @(negedge clk);

        // randomized traffic and configuration, with an occasional reset
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (i % 60 == 0)
                set_cfg($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom));
            wr_if.wr_valid = ($urandom_range(0, 5) == 0);
            wr_if.wr_data  = 8'($urandom);
            RST = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
        RST = 1'b0;
        wait_idle(2000);

`ifdef UART_TX_BREAK_EN
        // break held while idle, byte queued behind it
        set_cfg(1, 3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        brk = 1'b1;
        send(8'h5A);
        repeat (48) @(negedge clk);
        brk = 1'b0;
        wait_idle(100);
`endif

        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached at time %0t", $time);
        $fatal(1, "simulation time limit");
    end
endmodule
